// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a TDM link. It de-interleaves CHANNELS slots per
// frame into parallel registered outputs and tracks alignment with a HUNT/LOCKED FSM.
// Ports:
//   clk, rst                       clock and async active-high reset
//   din, din_valid, frame_sync     slot beat input; sync marks slot 0
//   ch_data                        last complete frame, ch k at [k*WIDTH +: WIDTH]
//   frame_valid                    1-cycle pulse when ch_data updates
//   locked, slot_idx, sync_err     alignment status
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic                      frame_valid,
    output logic                      locked,
    output logic [SW-1:0]             slot_idx,
    output logic                      sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_slot;
    logic [SW-1:0]         w_slot_nxt;
    logic                  w_wr;
    logic [SW-1:0]         w_wr_idx;
    logic                  w_done;
    logic                  w_err;
    logic [WIDTH-1:0]      r_shadow [CHANNELS-1];
    logic [CHANNELS*WIDTH-1:0] r_ch_data;
    logic                  r_frame_valid;
    logic                  r_sync_err;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wr        = 1'b0;
        w_wr_idx    = r_slot;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (din_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_wr        = 1'b1;
                        w_wr_idx    = '0;
                        w_slot_nxt  = ONE;
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // Early sync drops the partial frame and restarts at slot 0.
                        w_err      = (r_slot != '0);
                        w_wr       = 1'b1;
                        w_wr_idx   = '0;
                        w_slot_nxt = ONE;
                    end else if (r_slot == '0) begin
                        w_err       = 1'b1;
                        w_slot_nxt  = '0;
                        w_state_nxt = HUNT;
                    end else if (r_slot == LAST) begin
                        w_done     = 1'b1;
                        w_slot_nxt = '0;
                    end else begin
                        w_wr       = 1'b1;
                        w_slot_nxt = r_slot + ONE;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_slot_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= HUNT;
            r_slot        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_frame_valid <= w_done;
            r_sync_err    <= w_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_wr) begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
                if (w_wr_idx == SW'(k)) begin
                    r_shadow[k] <= din;
                end
            end
        end
    end

    // The last slot goes straight to the output, so frames run at full rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_data <= '0;
        end else if (w_done) begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
                r_ch_data[k*WIDTH +: WIDTH] <= r_shadow[k];
            end
            r_ch_data[(CHANNELS-1)*WIDTH +: WIDTH] <= din;
        end
    end

    assign ch_data     = r_ch_data;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == LOCKED);
    assign slot_idx    = r_slot;

endmodule
